reg_bank_arbiter: RTL and testbench



---
 rtl/reg_bank_arbiter_if.sv | 41 ++++
 rtl/reg_bank_arbiter.sv | 147 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_arbiter_if
//  Purpose  : Two-requester access bus for the shared register bank:
//             request/write-data side from the agents, grant/read-data side
//             from the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_bank_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
);
    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [AW-1:0]    addr0;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic             rvalid0;
    logic             rvalid1;
    logic             busy;

    // Requester side: drives requests, observes grants and read returns
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, busy
    );

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_arbiter
//  Purpose  : Shares DEPTH registers of WIDTH bits between two requesters.
//             One access is granted per cycle with round-robin priority on
//             conflict; read data returns registered one cycle after grant.
//  Revision : 1.0  initial release
// ============================================================================
module reg_bank_arbiter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                reset,
    reg_bank_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_t;

    prio_t            r_state;
    prio_t            w_state_next;

    logic             w_req0;
    logic             w_req1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc_we;
    logic [AW-1:0]    w_acc_addr;
    logic [WIDTH-1:0] w_acc_wdata;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_data;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;
    logic             r_rvalid0;
    logic             r_rvalid1;

    // Reset masks requests so no grant (and hence no write) occurs in a reset cycle
    assign w_req0 = bus.req0 & ~reset;
    assign w_req1 = bus.req1 & ~reset;

    // Priority state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PRIO0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant decode and next priority: winner of a grant hands priority to the other port
    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            PRIO0: begin
                if (w_req0) begin
                    w_gnt0       = 1'b1;
                    w_state_next = PRIO1;
                end else if (w_req1) begin
                    w_gnt1       = 1'b1;
                    w_state_next = PRIO0;
                end
            end
            PRIO1: begin
                if (w_req1) begin
                    w_gnt1       = 1'b1;
                    w_state_next = PRIO0;
                end else if (w_req0) begin
                    w_gnt0       = 1'b1;
                    w_state_next = PRIO1;
                end
            end
            default: begin
                w_state_next = PRIO0;
            end
        endcase
    end

    // At most one grant exists, so a single shared access path suffices
    assign w_acc_we    = w_gnt1 ? bus.we1    : bus.we0;
    assign w_acc_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_acc_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;
    assign w_wr_en     = (w_gnt0 | w_gnt1) & w_acc_we;

    // Read mux; addresses beyond DEPTH match no register and read as zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_acc_addr == AW'(i)) begin
                w_rd_data = r_mem[i];
            end
        end
    end

    // Register storage; out-of-range writes match no register and are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_acc_addr == AW'(i)) begin
                    r_mem[i] <= w_acc_wdata;
                end
            end
        end
    end

    // Read return registers: data captured on a read grant, valid pulses one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_gnt0 && !bus.we0) begin
                r_rdata0 <= w_rd_data;
            end
            if (w_gnt1 && !bus.we1) begin
                r_rdata1 <= w_rd_data;
            end
        end
    end

    // Reset forces the visible read return to idle, cancelling a pulse
    // launched by a read granted in the preceding cycle
    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.busy    = w_gnt0 | w_gnt1;
    assign bus.rvalid0 = r_rvalid0 & ~reset;
    assign bus.rvalid1 = r_rvalid1 & ~reset;
    assign bus.rdata0  = reset ? '0 : r_rdata0;
    assign bus.rdata1  = reset ? '0 : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_bank_arbiter
//  Purpose  : Directed self-checking bench for reg_bank_arbiter. Instance a
//             uses DEPTH=4, instance b uses DEPTH=3 for out-of-range access.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_bank_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    reg_bank_arbiter_if #(.WIDTH(4), .AW(2)) a ();
    reg_bank_arbiter_if #(.WIDTH(4), .AW(2)) b ();

    reg_bank_arbiter #(.WIDTH(4), .DEPTH(4), .AW(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a.slave)
    );

    reg_bank_arbiter #(.WIDTH(4), .DEPTH(3), .AW(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then apply new inputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a0(input logic req, input logic we, input logic [1:0] addr, input logic [3:0] data);
        a.req0 = req; a.we0 = we; a.addr0 = addr; a.wdata0 = data;
    endtask

    task automatic drive_a1(input logic req, input logic we, input logic [1:0] addr, input logic [3:0] data);
        a.req1 = req; a.we1 = we; a.addr1 = addr; a.wdata1 = data;
    endtask

    task automatic drive_b0(input logic req, input logic we, input logic [1:0] addr, input logic [3:0] data);
        b.req0 = req; b.we0 = we; b.addr0 = addr; b.wdata0 = data;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive_a0(1'b0, 1'b0, 2'd0, 4'h0);
        drive_a1(1'b0, 1'b0, 2'd0, 4'h0);
        drive_b0(1'b0, 1'b0, 2'd0, 4'h0);
        b.req1 = 1'b0; b.we1 = 1'b0; b.addr1 = 2'd0; b.wdata1 = 4'h0;

        // ---- Reset with both ports requesting, port0 writing reg1 ----
        reset = 1'b1;
        drive_a0(1'b1, 1'b1, 2'd1, 4'hF);
        drive_a1(1'b1, 1'b1, 2'd2, 4'hF);
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("rst_gnt0",    a.gnt0,    0);
            chk("rst_gnt1",    a.gnt1,    0);
            chk("rst_rvalid0", a.rvalid0, 0);
            chk("rst_rvalid1", a.rvalid1, 0);
            chk("rst_rdata0",  a.rdata0,  0);
            chk("rst_rdata1",  a.rdata1,  0);
            chk("rst_busy",    a.busy,    0);
            tick();
        end
        reset = 1'b0;
        drive_a0(1'b1, 1'b0, 2'd1, 4'h0);
        drive_a1(1'b0, 1'b0, 2'd0, 4'h0);
        #2 chk("rst_rd_gnt0", a.gnt0, 1);
        tick();
        drive_a0(1'b0, 1'b0, 2'd0, 4'h0);
        #2;
        chk("rst_rd_rvalid0", a.rvalid0, 1);
        chk("rst_rd_reg1",    a.rdata0,  4'h0);
        // state now PRIO1

        // ---- Single-port write then read ----
        drive_a0(1'b1, 1'b1, 2'd2, 4'hA);
        #2;
        chk("sp_wr_gnt0", a.gnt0, 1);
        chk("sp_wr_gnt1", a.gnt1, 0);
        tick();
        drive_a0(1'b1, 1'b0, 2'd2, 4'h0);
        #2;
        chk("sp_rd_gnt0",     a.gnt0,    1);
        chk("sp_rd_rvalid0q", a.rvalid0, 0);
        tick();
        drive_a0(1'b0, 1'b0, 2'd0, 4'h0);
        #2;
        chk("sp_rvalid0", a.rvalid0, 1);
        chk("sp_rdata0",  a.rdata0,  4'hA);
        chk("sp_rvalid1", a.rvalid1, 0);
        chk("sp_idle",    a.busy,    0);
        tick();
        #2 chk("sp_rvalid0_pulse", a.rvalid0, 0);
        // state PRIO1

        // ---- Preload: port0 reg3=C (-> PRIO1), port1 reg0=5 (-> PRIO0) ----
        drive_a0(1'b1, 1'b1, 2'd3, 4'hC);
        #2 chk("pre_gnt0", a.gnt0, 1);
        tick();
        drive_a0(1'b0, 1'b0, 2'd0, 4'h0);
        drive_a1(1'b1, 1'b1, 2'd0, 4'h5);
        #2 chk("pre_gnt1", a.gnt1, 1);
        tick();

        // ---- Contention: port0 reads reg0, port1 reads reg3, order 0,1,0,1 ----
        drive_a0(1'b1, 1'b0, 2'd0, 4'h0);
        drive_a1(1'b1, 1'b0, 2'd3, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("ct_gnt0", a.gnt0, (k % 2 == 0) ? 1 : 0);
            chk("ct_gnt1", a.gnt1, (k % 2 == 1) ? 1 : 0);
            chk("ct_busy", a.busy, 1);
            if (k > 0) begin
                chk("ct_rvalid0", a.rvalid0, (k % 2 == 1) ? 1 : 0);
                chk("ct_rvalid1", a.rvalid1, (k % 2 == 0) ? 1 : 0);
                if (k % 2 == 1) chk("ct_rdata0", a.rdata0, 4'h5);
                else            chk("ct_rdata1", a.rdata1, 4'hC);
            end
            tick();
        end
        drive_a0(1'b0, 1'b0, 2'd0, 4'h0);
        drive_a1(1'b0, 1'b0, 2'd0, 4'h0);
        #2;
        chk("ct_last_rvalid1", a.rvalid1, 1);
        chk("ct_last_rdata1",  a.rdata1,  4'hC);
        chk("ct_last_rvalid0", a.rvalid0, 0);
        chk("ct_rdata0_hold",  a.rdata0,  4'h5);
        // state PRIO0

        // ---- Cross-port read-after-write ----
        drive_a1(1'b1, 1'b1, 2'd1, 4'h7);
        #2 chk("raw_wr_gnt1", a.gnt1, 1);
        tick();
        drive_a1(1'b0, 1'b0, 2'd0, 4'h0);
        drive_a0(1'b1, 1'b0, 2'd1, 4'h0);
        #2 chk("raw_rd_gnt0", a.gnt0, 1);
        tick();
        drive_a0(1'b0, 1'b0, 2'd0, 4'h0);
        #2;
        chk("raw_rvalid0", a.rvalid0, 1);
        chk("raw_rdata0",  a.rdata0,  4'h7);

        // ---- Out of range on the DEPTH=3 instance ----
        for (int r = 0; r < 3; r++) begin
            drive_b0(1'b1, 1'b1, 2'(r), 4'(r + 1));
            tick();
        end
        drive_b0(1'b1, 1'b1, 2'd3, 4'h9);
        #2 chk("oor_wr_gnt0", b.gnt0, 1);
        tick();
        drive_b0(1'b1, 1'b0, 2'd3, 4'h0);
        #2 chk("oor_rd_gnt0", b.gnt0, 1);
        tick();
        drive_b0(1'b1, 1'b0, 2'd0, 4'h0);
        #2;
        chk("oor_rvalid0", b.rvalid0, 1);
        chk("oor_rdata0",  b.rdata0,  4'h0);
        for (int r = 1; r < 4; r++) begin
            tick();
            if (r < 3) drive_b0(1'b1, 1'b0, 2'(r), 4'h0);
            else       drive_b0(1'b0, 1'b0, 2'd0, 4'h0);
            #2;
            chk("oor_keep_rvalid", b.rvalid0, 1);
            chk("oor_keep_data",   b.rdata0,  32'(r));
        end

        // ---- Reset mid-operation ----
        tick();
        drive_a1(1'b1, 1'b0, 2'd3, 4'h0);
        #2 chk("mr_gnt1", a.gnt1, 1);
        tick();
        reset = 1'b1;
        drive_a0(1'b1, 1'b1, 2'd0, 4'hE);
        drive_a1(1'b1, 1'b0, 2'd1, 4'h0);
        #2;
        chk("mr_rvalid1", a.rvalid1, 0);
        chk("mr_gnt0",    a.gnt0,    0);
        chk("mr_gnt1r",   a.gnt1,    0);
        chk("mr_busy",    a.busy,    0);
        tick();
        reset = 1'b0;
        drive_a0(1'b1, 1'b0, 2'd0, 4'h0);
        #2;
        chk("mr_first_gnt0", a.gnt0, 1);
        chk("mr_first_gnt1", a.gnt1, 0);
        tick();
        #2;
        chk("mr_second_gnt1", a.gnt1,    1);
        chk("mr_rvalid0",     a.rvalid0, 1);
        chk("mr_reg0_clear",  a.rdata0,  4'h0);
        tick();
        drive_a0(1'b0, 1'b0, 2'd0, 4'h0);
        drive_a1(1'b0, 1'b0, 2'd0, 4'h0);
        #2;
        chk("mr_rvalid1_after", a.rvalid1, 1);
        chk("mr_reg1_clear",    a.rdata1,  4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
